// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the decoded-instruction payload.
package rv_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FUNCT_W = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned SEL_W   = 2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [FUNCT_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [FUNCT_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [FUNCT_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [FUNCT_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [FUNCT_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [FUNCT_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [FUNCT_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [FUNCT_W-1:0] ALU_SRA  = 4'b1101;
    localparam logic [FUNCT_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [FUNCT_W-1:0] ALU_AND  = 4'b0111;

    localparam logic [SEL_W-1:0] SRC_A_RS1  = 2'd0;
    localparam logic [SEL_W-1:0] SRC_A_PC   = 2'd1;
    localparam logic [SEL_W-1:0] SRC_A_ZERO = 2'd2;

    typedef struct packed {
        logic [FUNCT_W-1:0] alu_funct;
        logic [SEL_W-1:0]   src_a_sel;
        logic               src_b_imm;
        logic [INSTR_W-1:0] imm;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic               reg_write;
        logic               is_load;
        logic               is_store;
        logic               is_branch;
        logic               is_jump;
        logic               illegal;
    } dec_t;

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: raw instruction word to ALU/operand/class fields.
module id_decode
    import rv_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output dec_t               o_dec
);

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic [INSTR_W-1:0] w_imm_i;
    logic [INSTR_W-1:0] w_imm_s;
    logic [INSTR_W-1:0] w_imm_b;
    logic [INSTR_W-1:0] w_imm_u;
    logic [INSTR_W-1:0] w_imm_j;
    logic               w_f7_ok;
    dec_t               w_dec;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_f7_ok  = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        w_dec           = '0;
        w_dec.alu_funct = ALU_ADD;
        w_dec.src_a_sel = SRC_A_RS1;
        w_dec.rs1       = i_instr[19:15];
        w_dec.rs2       = i_instr[24:20];
        w_dec.rd        = i_instr[11:7];

        if (i_instr[1:0] != 2'b11) begin
            w_dec.illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_OP: begin
                    w_dec.alu_funct = {i_instr[30], w_funct3};
                    w_dec.reg_write = 1'b1;
                    if (!w_f7_ok || (i_instr[30] && w_funct3 != 3'b000 && w_funct3 != 3'b101))
                        w_dec.illegal = 1'b1;
                end
                OPC_OP_IMM: begin
                    w_dec.alu_funct = {i_instr[30] && (w_funct3 == 3'b101), w_funct3};
                    w_dec.src_b_imm = 1'b1;
                    w_dec.reg_write = 1'b1;
                    w_dec.imm       = w_imm_i;
                    if (w_funct3 == 3'b001) begin
                        w_dec.imm = INSTR_W'(i_instr[24:20]);
                        if (w_funct7 != 7'b0000000) w_dec.illegal = 1'b1;
                    end else if (w_funct3 == 3'b101) begin
                        w_dec.imm = INSTR_W'(i_instr[24:20]);
                        if (!w_f7_ok) w_dec.illegal = 1'b1;
                    end
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_dec.src_a_sel = (w_opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
                    w_dec.src_b_imm = 1'b1;
                    w_dec.imm       = w_imm_u;
                    w_dec.reg_write = 1'b1;
                end
                OPC_LOAD: begin
                    w_dec.src_b_imm = 1'b1;
                    w_dec.imm       = w_imm_i;
                    w_dec.reg_write = 1'b1;
                    w_dec.is_load   = 1'b1;
                end
                OPC_STORE: begin
                    w_dec.src_b_imm = 1'b1;
                    w_dec.imm       = w_imm_s;
                    w_dec.is_store  = 1'b1;
                end
                OPC_BRANCH: begin
                    w_dec.imm       = w_imm_b;
                    w_dec.is_branch = 1'b1;
                    case (w_funct3[2:1])
                        2'b00:   w_dec.alu_funct = ALU_SUB;
                        2'b10:   w_dec.alu_funct = ALU_SLT;
                        2'b11:   w_dec.alu_funct = ALU_SLTU;
                        default: w_dec.illegal   = 1'b1;
                    endcase
                end
                OPC_JAL: begin
                    w_dec.src_a_sel = SRC_A_PC;
                    w_dec.src_b_imm = 1'b1;
                    w_dec.imm       = w_imm_j;
                    w_dec.reg_write = 1'b1;
                    w_dec.is_jump   = 1'b1;
                end
                OPC_JALR: begin
                    w_dec.src_b_imm = 1'b1;
                    w_dec.imm       = w_imm_i;
                    w_dec.reg_write = 1'b1;
                    w_dec.is_jump   = 1'b1;
                    if (w_funct3 != 3'b000) w_dec.illegal = 1'b1;
                end
                default: w_dec.illegal = 1'b1;
            endcase
        end

        // An illegal instruction occupies the slot but must have no side effects.
        if (w_dec.illegal) begin
            w_dec.reg_write = 1'b0;
            w_dec.is_load   = 1'b0;
            w_dec.is_store  = 1'b0;
            w_dec.is_branch = 1'b0;
            w_dec.is_jump   = 1'b0;
        end
        if (w_dec.rd == '0) w_dec.reg_write = 1'b0;
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/id_stage.sv
// Decode pipeline stage: valid/ready input, single registered output slot with flush.
module id_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [FUNCT_W-1:0]  out_alu_funct,
    output logic [SEL_W-1:0]    out_src_a_sel,
    output logic                out_src_b_imm,
    output logic [XLEN-1:0]     out_imm,
    output logic [REG_W-1:0]    out_rs1,
    output logic [REG_W-1:0]    out_rs2,
    output logic [REG_W-1:0]    out_rd,
    output logic                out_reg_write,
    output logic                out_is_load,
    output logic                out_is_store,
    output logic                out_is_branch,
    output logic                out_is_jump,
    output logic                out_illegal
);

    dec_t            w_dec;
    dec_t            r_dec;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic            w_accept;

    id_decode u_decode (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Output slot: flush beats accept, accept beats consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_dec   <= w_dec;
            r_pc    <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_alu_funct = r_dec.alu_funct;
    assign out_src_a_sel = r_dec.src_a_sel;
    assign out_src_b_imm = r_dec.src_b_imm;
    assign out_imm       = XLEN'($signed(r_dec.imm));
    assign out_rs1       = r_dec.rs1;
    assign out_rs2       = r_dec.rs2;
    assign out_rd        = r_dec.rd;
    assign out_reg_write = r_dec.reg_write;
    assign out_is_load   = r_dec.is_load;
    assign out_is_store  = r_dec.is_store;
    assign out_is_branch = r_dec.is_branch;
    assign out_is_jump   = r_dec.is_jump;
    assign out_illegal   = r_dec.illegal;

endmodule
